hazard_ctrl_unit: RTL
=====================

# hazard_ctrl_unit

Parametrised, stateful hazard controller for the five-stage pipelined datapath, sitting beside the ID stage. It detects load-use and branch-operand data hazards, issues control-hazard flushes for taken branches and jumps, and sequences multi-cycle EX operations (mult/div) with an internal busy FSM and down-counter. It drives PC write-disable, IF/ID write-disable and flush, the ID/EX bubble mux, and the EX/MEM bubble.

## Interface
- REG_ADDR_W, 5, register-address width
- MC_LAT, 4, EX occupancy in cycles of a multi-cycle op; must be ≥1
- CNT_W, 32, width of the performance counters (macro-gated)

- Clk  in  1  clock, rising edge
- Rst  in  1  reset, synchronous, active-high
- ID_Instruction  in  32  instruction in ID; opcode [31:26], rs [25:21], rt [20:16]
- comp_in  in  1  ID branch comparator result, 1 = taken
- EX_Rd, MEM_Rd  in  REG_ADDR_W  destination register in EX / MEM
- EX_regWrite, EX_memRead, MEM_regWrite, MEM_memRead  in  1  stage control bits
- EX_mcStart  in  1  multi-cycle op is entering EX this cycle
- stall_mux  out  1  zero ID/EX control fields (bubble)
- flush  out  1  clear IF/ID
- PCoff  out  1  hold PC
- IFID_writeOff  out  1  hold IF/ID
- IDEX_writeOff  out  1  hold ID/EX
- EXMEM_bubble  out  1  zero EX/MEM control fields
- stall_cnt, flush_cnt  out  CNT_W  counters (only with HAZARD_PERF_CNT_EN)

## Operation
- Decode: useRs = opcode ∉ {2,3}; useRt = opcode ∈ {0,4,5,0x2B}; isBranch = opcode ∈ {4,5}; isJump = opcode ∈ {2,3}.
- match(Rd) = Rd≠0 && ((useRs && Rd==rs) || (useRt && Rd==rt)).
- loadUse = EX_memRead && EX_regWrite && match(EX_Rd).
- brDep = isBranch && ((EX_regWrite && match(EX_Rd)) || (MEM_memRead && MEM_regWrite && match(MEM_Rd))).
- dataStall = loadUse || brDep → stall_mux=1, PCoff=1, IFID_writeOff=1.
- FSM: IDLE, MC_BUSY. In IDLE, if EX_mcStart and MC_LAT>1: load cnt=MC_LAT-1 and go to MC_BUSY. In MC_BUSY: PCoff, IFID_writeOff, IDEX_writeOff, and EXMEM_bubble = 1; other outputs 0; cnt decrements each cycle; when cnt==1, return to IDLE next cycle. EX_mcStart is ignored in MC_BUSY.
- Priority: MC_BUSY > dataStall > flush. flush = (isJump || (isBranch && comp_in)) && !dataStall && state==IDLE.
- Outputs are combinational from state, cnt, and inputs, and are forced to 0 while Rst=1.

## Timing
- Reset: state IDLE, cnt 0, all outputs 0, counters 0, all on the first edge with Rst high. Rst mid-MC_BUSY aborts to IDLE.
- Hazard detection has zero latency: outputs are valid in the same cycle as the inputs.
- An MC op holds the pipe for exactly MC_LAT-1 cycles after the EX_mcStart cycle. With MC_LAT=1, MC_BUSY is never entered.
- A branch with an EX dependence stalls 1 cycle. A branch dependent on a MEM load stalls 1 cycle. A branch dependent on an EX load stalls 2 cycles (EX then MEM).
- The EX_mcStart cycle itself is IDLE: normal hazard logic applies in that cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt increments each cycle PCoff=1; flush_cnt increments each cycle flush=1. Both wrap modulo 2^CNT_W and are cleared by Rst.
- Not defined: both ports and all counter logic are absent.

## Structure
- Shared package hazard_pkg holds:
  - opcode constants OP_RTYPE=0, OP_J=2, OP_JAL=3, OP_BEQ=4, OP_BNE=5, OP_SW=0x2B
  - state enum {IDLE, MC_BUSY}
- One sub-module, mc_stall_counter, contains the FSM and down-counter. Inputs: Clk, Rst, start. Output: busy.

## Test plan
- Rst=1 for 2 cycles with EX_mcStart=1 → all outputs 0; state IDLE after release.
- ID=0x00432020 (add $4,$2,$3), EX_Rd=3, EX_memRead=1, EX_regWrite=1 → stall_mux=PCoff=IFID_writeOff=1. Repeat with EX_Rd=0 → all outputs 0.
- ID=0x10430004 (beq $2,$3), comp_in=1, EX_Rd=2, EX_regWrite=1 → stall, flush=0. Next cycle, with the hazard cleared → flush=1, PCoff=0.
- ID=0x08000010 (j) with no hazards → flush=1 only.
- EX_mcStart=1 for 1 cycle, MC_LAT=4 → PCoff/IFID_writeOff/IDEX_writeOff/EXMEM_bubble=1 for exactly 3 following cycles, then 0. Asserting Rst in the 2nd busy cycle → outputs 0 next cycle.
- With HAZARD_PERF_CNT_EN: the previous two scenarios run back-to-back from reset → stall_cnt=3, flush_cnt=1. With CNT_W=2 and 5 stall cycles → stall_cnt=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard controller: opcode constants and
// the multi-cycle sequencer state encoding.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {
    IDLE,
    MC_BUSY
  } mc_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_mc_stall_counter.sv
// Busy sequencer for multi-cycle EX ops: holds busy high for MC_LAT-1 cycles
// after the cycle in which start is seen in IDLE.
module mc_stall_counter
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LAT = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic start,
  output logic busy
);

  localparam int unsigned CNT_BITS = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MC_LAT - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  mc_state_e           state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && (MC_LAT > 1)) begin
          state_d = MC_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MC_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb busy = (state_q == MC_BUSY);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard controller: load-use / branch-operand stalls, taken-branch and
// jump flushes, and multi-cycle EX holds. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MC_LAT     = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [31:0]           ID_Instruction,
  input  logic                  comp_in,
  input  logic [REG_ADDR_W-1:0] EX_Rd,
  input  logic [REG_ADDR_W-1:0] MEM_Rd,
  input  logic                  EX_regWrite,
  input  logic                  EX_memRead,
  input  logic                  MEM_regWrite,
  input  logic                  MEM_memRead,
  input  logic                  EX_mcStart,
  output logic                  stall_mux,
  output logic                  flush,
  output logic                  PCoff,
  output logic                  IFID_writeOff,
  output logic                  IDEX_writeOff,
  output logic                  EXMEM_bubble
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs, rt;
  logic                  use_rs, use_rt, is_branch, is_jump;
  logic                  ex_match, mem_match, load_use, br_dep, data_stall;
  logic                  mc_busy;
  logic                  unused_instr_bits;

  always_comb begin
    opcode    = ID_Instruction[31:26];
    rs        = REG_ADDR_W'(ID_Instruction[25:21]);
    rt        = REG_ADDR_W'(ID_Instruction[20:16]);
    is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
    is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    use_rs    = !is_jump;
    use_rt    = (opcode == OP_RTYPE) || is_branch || (opcode == OP_SW);

    ex_match  = (EX_Rd != '0) &&
                ((use_rs && (EX_Rd == rs)) || (use_rt && (EX_Rd == rt)));
    mem_match = (MEM_Rd != '0) &&
                ((use_rs && (MEM_Rd == rs)) || (use_rt && (MEM_Rd == rt)));

    load_use   = EX_memRead && EX_regWrite && ex_match;
    // A branch resolves in ID, so even ALU results in EX are not yet forwardable.
    br_dep     = is_branch && ((EX_regWrite && ex_match) ||
                               (MEM_memRead && MEM_regWrite && mem_match));
    data_stall = load_use || br_dep;
  end

  always_comb unused_instr_bits = ^ID_Instruction[15:0];

  mc_stall_counter #(
    .MC_LAT(MC_LAT)
  ) u_mc_stall_counter (
    .Clk  (Clk),
    .Rst  (Rst),
    .start(EX_mcStart),
    .busy (mc_busy)
  );

  always_comb begin
    stall_mux     = 1'b0;
    flush         = 1'b0;
    PCoff         = 1'b0;
    IFID_writeOff = 1'b0;
    IDEX_writeOff = 1'b0;
    EXMEM_bubble  = 1'b0;
    if (!Rst) begin
      if (mc_busy) begin
        PCoff         = 1'b1;
        IFID_writeOff = 1'b1;
        IDEX_writeOff = 1'b1;
        EXMEM_bubble  = 1'b1;
      end else if (data_stall) begin
        stall_mux     = 1'b1;
        PCoff         = 1'b1;
        IFID_writeOff = 1'b1;
      end else if (is_jump || (is_branch && comp_in)) begin
        flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(PCoff);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end
`endif

endmodule
